// File: rtl/fifo_pkt_reader.sv
// Read-side packet parser behind a first-word-fall-through FIFO.
// Pops length-prefixed, checksummed packets and streams the payload with sop/eop markers.
module fifo_pkt_reader #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             rd_clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] rd_data,
   input  logic             rd_empty,
   output logic             rd_en,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sop,
   output logic             out_eop,
   output logic             pkt_done,
   output logic             pkt_err,
   output logic [CNT_W-1:0] pkt_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   typedef enum logic [1:0] {S_LEN, S_DATA, S_SUM} state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] remain;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] sum_c;
   logic             first_byte;
   logic             out_free;
   logic             pop_len;
   logic             pop_data;
   logic             pop_sum;

   assign sum_c = acc + rd_data;

   always_ff @(posedge rd_clk) begin
      if (reset) state <= S_LEN;
      else       state <= state_next;
   end

   // Pops in S_DATA and S_SUM wait for a free output register so status never overtakes the eop byte.
   always_comb begin
      state_next = state;
      pop_len    = 1'b0;
      pop_data   = 1'b0;
      pop_sum    = 1'b0;
      out_free   = !out_valid || out_ready;
      if (!reset) begin
         case (state)
            S_LEN: begin
               pop_len = !rd_empty;
               if (pop_len) state_next = (rd_data == '0) ? S_SUM : S_DATA;
            end
            S_DATA: begin
               pop_data = !rd_empty && out_free;
               if (pop_data && remain == WIDTH'(1)) state_next = S_SUM;
            end
            S_SUM: begin
               pop_sum = !rd_empty && out_free;
               if (pop_sum) state_next = S_LEN;
            end
            default: state_next = S_LEN;
         endcase
      end
      rd_en = pop_len || pop_data || pop_sum;
   end

   always_ff @(posedge rd_clk) begin
      if (reset) begin
         out_data   <= '0;
         out_valid  <= 1'b0;
         out_sop    <= 1'b0;
         out_eop    <= 1'b0;
         pkt_done   <= 1'b0;
         pkt_err    <= 1'b0;
         pkt_cnt    <= '0;
         err_cnt    <= '0;
         acc        <= '0;
         remain     <= '0;
         first_byte <= 1'b0;
      end else begin
         pkt_done <= 1'b0;
         pkt_err  <= 1'b0;
         if (pop_data) begin
            out_valid  <= 1'b1;
            out_data   <= rd_data;
            out_sop    <= first_byte;
            out_eop    <= (remain == WIDTH'(1));
            acc        <= sum_c;
            remain     <= remain - WIDTH'(1);
            first_byte <= 1'b0;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (pop_len) begin
            remain     <= rd_data;
            acc        <= rd_data;
            first_byte <= 1'b1;
         end
         // A packet is good when length, payload and checksum sum to zero.
         if (pop_sum) begin
            pkt_done <= 1'b1;
            pkt_err  <= (sum_c != '0);
            pkt_cnt  <= pkt_cnt + CNT_W'(1);
            if (sum_c != '0) err_cnt <= err_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/fifo_pkt_reader.md
# fifo_pkt_reader

Read-side consumer for the team's FIFO. It pops bytes from the FIFO read port in the `rd_clk` domain and parses length-prefixed, checksummed packets. It forwards the payload on a valid/ready stream with start- and end-of-packet markers, and reports per-packet status plus running packet and error counters. It sits directly behind the FIFO's `data_out`/`rd_empty` outputs, on the side opposite the writer.

## Interface
- `WIDTH`, 8: FIFO word width. Length and checksum fields are also `WIDTH` bits; only 8 is verified.
- `CNT_W`, 16: width of the packet and error counters.

- `rd_clk` input 1: sole clock. Every flop is on `posedge rd_clk`.
- `reset` input 1: reset. One clock; reset is synchronous and active-high.
- `rd_data` input `WIDTH`: FIFO head word. It is valid whenever `rd_empty`=0 (first-word fall-through).
- `rd_empty` input 1: FIFO empty.
- `rd_en` output 1: pop. It is combinational and is never high while `rd_empty`=1.
- `out_data` output `WIDTH`: payload byte.
- `out_valid` output 1: payload valid.
- `out_ready` input 1: downstream accept.
- `out_sop` output 1: first payload byte, qualified by `out_valid`.
- `out_eop` output 1: last payload byte, qualified by `out_valid`.
- `pkt_done` output 1: one-cycle pulse after the checksum byte is consumed.
- `pkt_err` output 1: checksum failure, valid only while `pkt_done`=1.
- `pkt_cnt` output `CNT_W`: number of completed packets, good or bad.
- `err_cnt` output `CNT_W`: number of bad-checksum packets.

## Operation
Packet format on the FIFO:
- Byte 1 is length L (0..2^WIDTH−1).
- Next come L payload bytes.
- Last comes one checksum byte C.
- The packet is good when the sum of L, all payload bytes and C is 0 mod 2^WIDTH. The sum is a `WIDTH`-bit accumulator with carries discarded.

States:
- S_LEN
  - `rd_en` = !`rd_empty`.
  - On pop: latch L into `remain`, set `acc` = L.
  - Go to S_DATA if L≠0, or S_SUM if L=0.
- S_DATA
  - `rd_en` = !`rd_empty` && (!`out_valid` || `out_ready`).
  - On pop: load the output register with `out_valid`=1, `out_data`=`rd_data`, `out_sop` = (first payload byte), `out_eop` = (`remain`==1). Then `acc` += `rd_data` and `remain` −= 1.
  - After the pop with `remain`==1, go to S_SUM.
- S_SUM
  - `rd_en` = !`rd_empty` && (!`out_valid` || `out_ready`). This keeps status from preceding acceptance of the eop byte.
  - On pop: `pkt_done`=1 next cycle and `pkt_err` = ((`acc`+`rd_data`) mod 2^WIDTH ≠ 0).
  - `pkt_cnt` += 1. `err_cnt` += 1 if the packet is bad.
  - Return to S_LEN.

Output register:
- `out_valid` clears when `out_ready`=1 and no new pop occurs in the same cycle.
- `out_data`, `out_sop` and `out_eop` hold stable while `out_valid`=1 && !`out_ready`.

Counters:
- Both counters wrap mod 2^CNT_W and do not saturate.

Bad packets:
- Payload of a bad packet has already been forwarded. Only `pkt_err` flags it.

## Timing
Reset values:
- State is S_LEN.
- `out_valid`, `out_sop`, `out_eop`, `pkt_done` and `pkt_err` are 0.
- `out_data`, `pkt_cnt`, `err_cnt`, `acc` and `remain` are 0.
- `rd_en` is 0 during reset.

Reset mid-packet:
- The partial packet is abandoned and the output register is cleared, even if `out_valid` was high and unaccepted.
- The next popped byte is treated as a length.
- Already-popped bytes are not replayed.

Latency:
- Payload pop at edge N gives `out_valid`=1 after edge N.
- Checksum pop at edge N gives `pkt_done`=1 for the single cycle after edge N.

Throughput:
- One FIFO word per cycle with `out_ready` held high.
- A packet with L bytes takes L+2 pops.
- Back-to-back packets need no idle cycle. The next length byte may pop the cycle after the checksum pop.

Boundary conditions:
- `rd_empty` rising mid-packet: the FSM stalls in place with no timeout.
- `out_ready` low with a full output register: no pop. This holds in S_SUM as well.
- L = 2^WIDTH−1 is legal. `remain` is `WIDTH` bits wide.

## Test plan
- **Basic packet:** FIFO 03 11 22 33 97, `out_ready`=1 → out 11(sop), 22, 33(eop) on consecutive cycles; `pkt_done`=1, `pkt_err`=0 the cycle after the 97 pop; `pkt_cnt`=1.
- **Backpressure:** same packet, `out_ready` low for 3 cycles while 22 is presented → 22 held stable; no `rd_en` during the stall; `pkt_done` pulse only after the 33(eop) handshake.
- **Zero length and bad checksum:** 00 00, then 02 AA BB 00 → first `pkt_done`/`pkt_err`=0; second yields AA(sop), BB(eop), then `pkt_err`=1; `pkt_cnt`=2, `err_cnt`=1.
- **Empty gaps:** `rd_empty` toggled every other cycle through 03 01 02 03 F7 → no pop while empty; output 01 02 03; `pkt_err`=0.
- **Reset mid-packet:** after 04 10 20 popped, assert `reset` for 1 cycle, then feed 01 5A A5 → all outputs 0 during reset; then 5A(sop, eop) and `pkt_done` with `pkt_err`=0; `pkt_cnt`=1.
- **Back-to-back and counter wrap:** `CNT_W`=2, five consecutive good 1-byte packets with no gaps → one pop per cycle; `pkt_cnt` ends at 1.
